// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame slot sequencer: header pilots, payload data with interleaved pilots
module frame_sequencer #(
    parameter int CNT_W  = 13,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              advance,
    input  logic [CNT_W-1:0]  frame_length,
    input  logic [CNT_W-1:0]  header_len,
    input  logic [CNT_W-1:0]  pilot_period,
    output logic              slot_valid,
    output logic              sel_pilot,
    output logic              start_frame,
    output logic              end_frame,
    output logic [CNT_W-1:0]  sym_idx,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_PILOT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);
    localparam logic [FCNT_W-1:0] ONE_F  = FCNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    fl_q, fl_d;
    logic [CNT_W-1:0]    hl_q, hl_d;
    logic [CNT_W-1:0]    pp_q, pp_d;
    logic [CNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [CNT_W-1:0]    sym_idx_q, sym_idx_d;
    logic [CNT_W-1:0]    since_q, since_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                start_q, start_d;
    logic                last_data;
    logic                launch;
    logic [CNT_W-1:0]    since_inc;

    assign last_data = (sym_idx_q == fl_q - ONE_C);
    assign since_inc = since_q + ONE_C;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fl_q        <= '0;
            hl_q        <= '0;
            pp_q        <= '0;
            hdr_cnt_q   <= '0;
            sym_idx_q   <= '0;
            since_q     <= '0;
            frame_cnt_q <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fl_q        <= fl_d;
            hl_q        <= hl_d;
            pp_q        <= pp_d;
            hdr_cnt_q   <= hdr_cnt_d;
            sym_idx_q   <= sym_idx_d;
            since_q     <= since_d;
            frame_cnt_q <= frame_cnt_d;
            start_q     <= start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fl_d        = fl_q;
        hl_d        = hl_q;
        pp_d        = pp_q;
        hdr_cnt_d   = hdr_cnt_q;
        sym_idx_d   = sym_idx_q;
        since_d     = since_q;
        frame_cnt_d = frame_cnt_q;
        start_d     = start_q;
        launch      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    launch = 1'b1;
                end
            end
            ST_HEADER: begin
                if (advance) begin
                    start_d = 1'b0;
                    if (hdr_cnt_q == hl_q - ONE_C) begin
                        state_d = ST_DATA;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + ONE_C;
                    end
                end
            end
            ST_DATA: begin
                if (advance) begin
                    start_d = 1'b0;
                    if (last_data) begin
                        // End of frame wins over any pilot that would otherwise follow
                        frame_cnt_d = frame_cnt_q + ONE_F;
                        if (enable) begin
                            launch = 1'b1;
                        end else begin
                            state_d   = ST_IDLE;
                            hdr_cnt_d = '0;
                            sym_idx_d = '0;
                            since_d   = '0;
                        end
                    end else begin
                        sym_idx_d = sym_idx_q + ONE_C;
                        if (pp_q != '0 && since_inc == pp_q) begin
                            state_d = ST_PILOT;
                            since_d = '0;
                        end else begin
                            since_d = since_inc;
                        end
                    end
                end
            end
            ST_PILOT: begin
                if (advance) begin
                    start_d = 1'b0;
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch) begin
            fl_d      = (frame_length == '0) ? ONE_C : frame_length;
            hl_d      = header_len;
            pp_d      = pilot_period;
            hdr_cnt_d = '0;
            sym_idx_d = '0;
            since_d   = '0;
            start_d   = 1'b1;
            state_d   = (header_len != '0) ? ST_HEADER : ST_DATA;
        end
    end

    assign slot_valid  = (state_q != ST_IDLE);
    assign sel_pilot   = (state_q == ST_HEADER) || (state_q == ST_PILOT);
    assign start_frame = start_q;
    assign end_frame   = (state_q == ST_DATA) && last_data;
    assign sym_idx     = sym_idx_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer
module tb_frame_sequencer;

    localparam int CNT_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              advance;
    logic [CNT_W-1:0]  frame_length;
    logic [CNT_W-1:0]  header_len;
    logic [CNT_W-1:0]  pilot_period;
    logic              slot_valid, sel_pilot, start_frame, end_frame;
    logic [CNT_W-1:0]  sym_idx;
    logic [15:0]       frame_cnt;
    logic              w_slot_valid, w_sel_pilot, w_start_frame, w_end_frame;
    logic [CNT_W-1:0]  w_sym_idx;
    logic [1:0]        w_frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    frame_sequencer #(.CNT_W(CNT_W), .FCNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .advance(advance),
        .frame_length(frame_length), .header_len(header_len), .pilot_period(pilot_period),
        .slot_valid(slot_valid), .sel_pilot(sel_pilot), .start_frame(start_frame),
        .end_frame(end_frame), .sym_idx(sym_idx), .frame_cnt(frame_cnt)
    );

    frame_sequencer #(.CNT_W(CNT_W), .FCNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .enable(enable), .advance(advance),
        .frame_length(frame_length), .header_len(header_len), .pilot_period(pilot_period),
        .slot_valid(w_slot_valid), .sel_pilot(w_sel_pilot), .start_frame(w_start_frame),
        .end_frame(w_end_frame), .sym_idx(w_sym_idx), .frame_cnt(w_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {valid, pilot, start, end, idx}
    function automatic logic [16:0] mk(input logic p, input logic s, input logic e, input int idx);
        return {1'b1, p, s, e, idx[12:0]};
    endfunction

    function automatic logic [31:0] slot_now();
        return {15'd0, slot_valid, sel_pilot, start_frame, end_frame, sym_idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        exp_q = {};
        exp_q.push_back(mk(1, 1, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 1));
        exp_q.push_back(mk(1, 0, 0, 2));
        exp_q.push_back(mk(0, 0, 0, 2));
        exp_q.push_back(mk(0, 0, 0, 3));
        exp_q.push_back(mk(1, 0, 0, 4));
        exp_q.push_back(mk(0, 0, 1, 4));
    endtask

    // Walks exp_q one slot per advance; stall inserts two advance=0 cycles per slot,
    // drop_at clears enable while that slot is presented.
    task automatic run_exp(input string tag, input bit stall, input int drop_at);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_slot%0d", tag, i), slot_now(), {15'd0, exp_q[i]});
            if (i == drop_at) enable = 1'b0;
            if (stall) begin
                advance = 1'b0;
                tick();
                check($sformatf("%s_hold%0d", tag, i), slot_now(), {15'd0, exp_q[i]});
                tick();
                check($sformatf("%s_hold%0db", tag, i), slot_now(), {15'd0, exp_q[i]});
                advance = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; advance = 1'b0;
        frame_length = '0; header_len = '0; pilot_period = '0;
        tick(); tick();
        check("reset_slot", slot_now(), 32'd0);
        check("reset_fcnt", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b1;
        advance = 1'b1;
        tick();
        check("idle_ignores_advance", slot_now(), 32'd0);

        // Basic frame, back-to-back into the next one
        header_len = 13'd2; frame_length = 13'd5; pilot_period = 13'd2; enable = 1'b1;
        tick();
        load_basic();
        run_exp("basic", 1'b0, -1);
        check("basic_fcnt", {16'd0, frame_cnt}, 32'd1);
        check("basic_next_start", slot_now(), {15'd0, mk(1, 1, 0, 0)});

        // Stalled frame must replay the same slot sequence
        run_exp("stall", 1'b1, -1);
        check("stall_fcnt", {16'd0, frame_cnt}, 32'd2);

        // Graceful stop at D1, new frame_length only seen by the next frame
        frame_length = 13'd7;
        run_exp("stop", 1'b0, 3);
        check("stop_idle", slot_now(), 32'd0);
        check("stop_fcnt", {16'd0, frame_cnt}, 32'd3);
        tick();
        check("stop_idle_hold", slot_now(), 32'd0);
        enable = 1'b1;
        tick();
        exp_q = {};
        exp_q.push_back(mk(1, 1, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 1));
        exp_q.push_back(mk(1, 0, 0, 2));
        exp_q.push_back(mk(0, 0, 0, 2));
        exp_q.push_back(mk(0, 0, 0, 3));
        exp_q.push_back(mk(1, 0, 0, 4));
        exp_q.push_back(mk(0, 0, 0, 4));
        exp_q.push_back(mk(0, 0, 0, 5));
        exp_q.push_back(mk(1, 0, 0, 6));
        exp_q.push_back(mk(0, 0, 1, 6));
        run_exp("fl7", 1'b0, 0);
        check("fl7_idle", slot_now(), 32'd0);
        check("fl7_fcnt", {16'd0, frame_cnt}, 32'd4);

        // No pilots, no header
        header_len = 13'd0; frame_length = 13'd3; pilot_period = 13'd0; enable = 1'b1;
        tick();
        exp_q = {};
        exp_q.push_back(mk(0, 1, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 1));
        exp_q.push_back(mk(0, 0, 1, 2));
        run_exp("nopilot", 1'b0, 0);
        check("nopilot_idle", slot_now(), 32'd0);

        // frame_length=0 collapses to a single start+end slot
        frame_length = 13'd0; enable = 1'b1;
        tick();
        check("single_slot", slot_now(), {15'd0, mk(0, 1, 1, 0)});
        enable = 1'b0;
        tick();
        check("single_idle", slot_now(), 32'd0);
        check("single_fcnt", {16'd0, frame_cnt}, 32'd6);

        // Reset during the first interleaved pilot
        header_len = 13'd2; frame_length = 13'd5; pilot_period = 13'd2; enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("pre_reset_pilot", slot_now(), {15'd0, mk(1, 0, 0, 2)});
        rst = 1'b0;
        tick();
        check("midreset_slot", slot_now(), 32'd0);
        check("midreset_fcnt", {16'd0, frame_cnt}, 32'd0);
        check("midreset_wfcnt", {30'd0, w_frame_cnt}, 32'd0);
        rst = 1'b1;
        tick();
        check("restart_first", slot_now(), {15'd0, mk(1, 1, 0, 0)});

        // Five frames: 16-bit counter 1..5, 2-bit counter wraps 1,2,3,0,1
        for (int f = 1; f <= 5; f++) begin
            load_basic();
            run_exp($sformatf("wrap%0d", f), 1'b0, (f == 5) ? 0 : -1);
            check($sformatf("wrap_fcnt%0d", f), {16'd0, frame_cnt}, f);
            check($sformatf("wrap_w%0d", f), {30'd0, w_frame_cnt}, f % 4);
        end
        check("wrap_idle", slot_now(), 32'd0);

        // Period equal to length: no pilot; then length 10 gives one pilot after D4
        header_len = 13'd0; frame_length = 13'd5; pilot_period = 13'd5; enable = 1'b1;
        tick();
        exp_q = {};
        exp_q.push_back(mk(0, 1, 0, 0));
        for (int i = 1; i < 4; i++) exp_q.push_back(mk(0, 0, 0, i));
        exp_q.push_back(mk(0, 0, 1, 4));
        frame_length = 13'd10;
        run_exp("pp5fl5", 1'b0, -1);
        exp_q = {};
        exp_q.push_back(mk(0, 1, 0, 0));
        for (int i = 1; i < 5; i++) exp_q.push_back(mk(0, 0, 0, i));
        exp_q.push_back(mk(1, 0, 0, 5));
        for (int i = 5; i < 9; i++) exp_q.push_back(mk(0, 0, 0, i));
        exp_q.push_back(mk(0, 0, 1, 9));
        run_exp("pp5fl10", 1'b0, 0);
        check("pp5fl10_idle", slot_now(), 32'd0);
        check("final_fcnt", {16'd0, frame_cnt}, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
